// File: rtl/rom_loader.sv
// rom_loader: receives a byte stream (header N, N big-endian 28-bit words in
// 4-byte frames, XOR checksum) and writes each word into instruction memory,
// holding the processor in reset until a load completes with a good checksum.
module rom_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              iByteValid,
   input  logic [7:0]        iByte,
   output logic              oByteReady,
   output logic              oWriteEnable,
   output logic [ADDR_W-1:0] oWriteAddress,
   output logic [27:0]       oInstruction,
   output logic              oCpuReset,
   input  logic              iStart,
   output logic              oDone,
   output logic              oError
);

   typedef enum logic [2:0] {
      HDR   = 3'd0,
      DATA  = 3'd1,
      WRITE = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4,
      ERROR = 3'd5
   } tState;

   tState             stateReg, stateNext;
   logic [8:0]        wordTotalReg, wordTotalNext;   // N, with header 0 meaning 256
   logic [8:0]        wordCountReg, wordCountNext;
   logic [1:0]        byteIdxReg, byteIdxNext;
   logic [7:0]        xorReg, xorNext;
   logic [19:0]       upperReg, upperNext;           // instruction bits [27:8] being assembled
   logic [27:0]       instrReg, instrNext;
   logic [ADDR_W-1:0] addrReg, addrNext;

   logic canAccept;
   logic accept;

   assign canAccept = (stateReg == HDR) || (stateReg == DATA) || (stateReg == CHECK);
   assign accept    = iByteValid && canAccept;

   // Status outputs are gated by Reset so they show reset values during the
   // very cycle Reset is low, even if the state register still holds WRITE/DONE.
   assign oByteReady    = Reset && canAccept;
   assign oWriteEnable  = Reset && (stateReg == WRITE);
   assign oDone         = Reset && (stateReg == DONE);
   assign oError        = Reset && (stateReg == ERROR);
   assign oCpuReset     = !(Reset && (stateReg == DONE));
   assign oWriteAddress = addrReg;
   assign oInstruction  = instrReg;

   // Next-state and datapath update; only accepted bytes touch byte-related state.
   always_comb begin
      stateNext     = stateReg;
      wordTotalNext = wordTotalReg;
      wordCountNext = wordCountReg;
      byteIdxNext   = byteIdxReg;
      xorNext       = xorReg;
      upperNext     = upperReg;
      instrNext     = instrReg;
      addrNext      = addrReg;
      case (stateReg)
         HDR: begin
            if (accept) begin
               wordTotalNext = (iByte == 8'h00) ? 9'd256 : {1'b0, iByte};
               xorNext       = iByte;
               wordCountNext = 9'd0;
               byteIdxNext   = 2'd0;
               stateNext     = DATA;
            end
         end
         DATA: begin
            if (accept) begin
               xorNext = xorReg ^ iByte;
               case (byteIdxReg)
                  2'd0: begin
                     if (iByte[7:4] != 4'h0) begin
                        stateNext = ERROR;
                     end else begin
                        upperNext[19:16] = iByte[3:0];
                        byteIdxNext      = 2'd1;
                     end
                  end
                  2'd1: begin
                     upperNext[15:8] = iByte;
                     byteIdxNext     = 2'd2;
                  end
                  2'd2: begin
                     upperNext[7:0] = iByte;
                     byteIdxNext    = 2'd3;
                  end
                  default: begin
                     instrNext   = {upperReg, iByte};
                     byteIdxNext = 2'd0;
                     stateNext   = WRITE;
                  end
               endcase
            end
         end
         WRITE: begin
            addrNext      = addrReg + {{(ADDR_W-1){1'b0}}, 1'b1};
            wordCountNext = wordCountReg + 9'd1;
            stateNext     = (wordCountReg + 9'd1 == wordTotalReg) ? CHECK : DATA;
         end
         CHECK: begin
            if (accept) begin
               stateNext = (iByte == xorReg) ? DONE : ERROR;
            end
         end
         DONE, ERROR: begin
            if (iStart) begin
               addrNext  = '0;
               stateNext = HDR;
            end
         end
         default: stateNext = HDR;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         stateReg     <= HDR;
         wordTotalReg <= 9'd0;
         wordCountReg <= 9'd0;
         byteIdxReg   <= 2'd0;
         xorReg       <= 8'd0;
         upperReg     <= 20'd0;
         instrReg     <= 28'd0;
         addrReg      <= '0;
      end else begin
         stateReg     <= stateNext;
         wordTotalReg <= wordTotalNext;
         wordCountReg <= wordCountNext;
         byteIdxReg   <= byteIdxNext;
         xorReg       <= xorNext;
         upperReg     <= upperNext;
         instrReg     <= instrNext;
         addrReg      <= addrNext;
      end
   end

endmodule

// File: tb/tb_rom_loader.sv
// Directed testbench for rom_loader: feeds byte streams through the
// valid/ready handshake and checks the write strobes and status outputs.
module tb_rom_loader;

   logic        Clock;
   logic        Reset;
   logic        iByteValid;
   logic [7:0]  iByte;
   logic        oByteReady;
   logic        oWriteEnable;
   logic [7:0]  oWriteAddress;
   logic [27:0] oInstruction;
   logic        oCpuReset;
   logic        iStart;
   logic        oDone;
   logic        oError;

   int nCompared;
   int nMismatched;

   logic [7:0]  stream[$];
   logic [7:0]  wrAddr[$];
   logic [27:0] wrData[$];

   rom_loader #(.ADDR_W(8)) dut (
      .Clock(Clock),
      .Reset(Reset),
      .iByteValid(iByteValid),
      .iByte(iByte),
      .oByteReady(oByteReady),
      .oWriteEnable(oWriteEnable),
      .oWriteAddress(oWriteAddress),
      .oInstruction(oInstruction),
      .oCpuReset(oCpuReset),
      .iStart(iStart),
      .oDone(oDone),
      .oError(oError)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Record every write strobe seen away from the active edge.
   always @(negedge Clock) begin
      if (oWriteEnable === 1'b1) begin
         wrAddr.push_back(oWriteAddress);
         wrData.push_back(oInstruction);
      end
   end

   // Offer one byte after an optional idle gap; returns at the negedge after transfer.
   task automatic sendByte(input logic [7:0] b, input int gap);
      int waited;
      iByteValid = 1'b0;
      repeat (gap) begin
         iByte = 8'($urandom);
         @(negedge Clock);
      end
      iByteValid = 1'b1;
      iByte      = b;
      waited     = 0;
      while (oByteReady !== 1'b1 && waited < 50) begin
         @(negedge Clock);
         waited++;
      end
      if (oByteReady !== 1'b1) begin
         nCompared++;
         nMismatched++;
         $display("FAIL handshake_timeout: byte %02h not taken, oByteReady=%b required 1", b, oByteReady);
      end else begin
         @(posedge Clock);
      end
      @(negedge Clock);
      iByteValid = 1'b0;
   endtask

   task automatic sendAll(input int maxGap);
      foreach (stream[i]) sendByte(stream[i], $urandom_range(maxGap, 0));
   endtask

   task automatic pulseStart();
      iStart = 1'b1;
      @(negedge Clock);
      iStart = 1'b0;
   endtask

   task automatic clearWrites();
      wrAddr.delete();
      wrData.delete();
   endtask

   task automatic buildGood(input logic [7:0] ck);
      stream = {8'h02, 8'h01, 8'h23, 8'h45, 8'h67, 8'h0A, 8'hBC, 8'hDE, 8'hF0, ck};
   endtask

   // Checks the two writes and final status of the 2-word reference stream.
   task automatic checkTwoWords(input string tag, input logic expDone);
      nCompared++;
      if (wrAddr.size() !== 2) begin
         nMismatched++;
         $display("FAIL %s_write_count: got %0d required 2", tag, wrAddr.size());
      end
      if (wrAddr.size() >= 2) begin
         nCompared++;
         if (wrAddr[0] !== 8'd0 || wrData[0] !== 28'h1234567) begin
            nMismatched++;
            $display("FAIL %s_write0: got %07h@%0d required 1234567@0", tag, wrData[0], wrAddr[0]);
         end
         nCompared++;
         if (wrAddr[1] !== 8'd1 || wrData[1] !== 28'hABCDEF0) begin
            nMismatched++;
            $display("FAIL %s_write1: got %07h@%0d required abcdef0@1", tag, wrData[1], wrAddr[1]);
         end
      end
      nCompared++;
      if (oDone !== expDone || oError !== !expDone || oCpuReset !== !expDone) begin
         nMismatched++;
         $display("FAIL %s_status: got done=%b err=%b cpuRst=%b required done=%b err=%b cpuRst=%b",
                  tag, oDone, oError, oCpuReset, expDone, !expDone, !expDone);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b0; iByteValid = 1'b0; iByte = 8'h00; iStart = 1'b0;
      repeat (3) @(negedge Clock);
      nCompared++;
      if (oByteReady !== 1'b0 || oWriteEnable !== 1'b0 || oDone !== 1'b0 || oError !== 1'b0) begin
         nMismatched++;
         $display("FAIL reset_flags: got rdy=%b we=%b done=%b err=%b required 0 0 0 0",
                  oByteReady, oWriteEnable, oDone, oError);
      end
      nCompared++;
      if (oWriteAddress !== 8'd0 || oInstruction !== 28'd0 || oCpuReset !== 1'b1) begin
         nMismatched++;
         $display("FAIL reset_values: got addr=%0d instr=%07h cpuRst=%b required 0 0000000 1",
                  oWriteAddress, oInstruction, oCpuReset);
      end
      Reset = 1'b1;
      #1;
      nCompared++;
      if (oByteReady !== 1'b1) begin
         nMismatched++;
         $display("FAIL reset_release_ready: got %b required 1", oByteReady);
      end
      @(negedge Clock);
      $display("test_reset done");
   endtask

   task automatic test_good_load();
      buildGood(8'h9A);
      clearWrites();
      for (int i = 0; i < 5; i++) sendByte(stream[i], 0);
      nCompared++;
      if (oWriteEnable !== 1'b1 || oByteReady !== 1'b0 || oWriteAddress !== 8'd0 || oInstruction !== 28'h1234567) begin
         nMismatched++;
         $display("FAIL good_write_cycle: got we=%b rdy=%b %07h@%0d required 1 0 1234567@0",
                  oWriteEnable, oByteReady, oInstruction, oWriteAddress);
      end
      @(negedge Clock);
      nCompared++;
      if (oWriteEnable !== 1'b0 || oWriteAddress !== 8'd1 || oInstruction !== 28'h1234567) begin
         nMismatched++;
         $display("FAIL good_after_write: got we=%b %07h@%0d required 0 1234567@1",
                  oWriteEnable, oInstruction, oWriteAddress);
      end
      for (int i = 5; i < 10; i++) sendByte(stream[i], 0);
      checkTwoWords("good", 1'b1);
      $display("test_good_load done: %0d writes", wrAddr.size());
   endtask

   task automatic test_restart();
      pulseStart();
      nCompared++;
      if (oDone !== 1'b0 || oError !== 1'b0 || oCpuReset !== 1'b1 || oWriteAddress !== 8'd0 || oByteReady !== 1'b1) begin
         nMismatched++;
         $display("FAIL restart: got done=%b err=%b cpuRst=%b addr=%0d rdy=%b required 0 0 1 0 1",
                  oDone, oError, oCpuReset, oWriteAddress, oByteReady);
      end
      $display("test_restart done");
   endtask

   task automatic test_bad_checksum();
      buildGood(8'h9B);
      clearWrites();
      sendAll(0);
      checkTwoWords("badck", 1'b0);
      $display("test_bad_checksum done: %0d writes", wrAddr.size());
   endtask

   task automatic test_bad_opcode();
      clearWrites();
      sendByte(8'h01, 0);
      sendByte(8'h1F, 0);
      repeat (2) @(negedge Clock);
      nCompared++;
      if (oError !== 1'b1 || oDone !== 1'b0 || oCpuReset !== 1'b1 || oByteReady !== 1'b0) begin
         nMismatched++;
         $display("FAIL opcode_status: got err=%b done=%b cpuRst=%b rdy=%b required 1 0 1 0",
                  oError, oDone, oCpuReset, oByteReady);
      end
      nCompared++;
      if (wrAddr.size() !== 0) begin
         nMismatched++;
         $display("FAIL opcode_no_write: got %0d writes required 0", wrAddr.size());
      end
      $display("test_bad_opcode done");
   endtask

   // Random idle gaps, iStart held high during the load (must be ignored).
   task automatic test_gaps();
      buildGood(8'h9A);
      clearWrites();
      iStart = 1'b1;
      for (int i = 0; i < 9; i++) sendByte(stream[i], $urandom_range(3, 0));
      iStart = 1'b0;
      sendByte(stream[9], 2);
      checkTwoWords("gaps", 1'b1);
      $display("test_gaps done: %0d writes", wrAddr.size());
   endtask

   task automatic test_full_256();
      logic [27:0] expData[256];
      logic [7:0]  ck;
      logic [7:0]  iv;
      logic [7:0]  b0, b1, b2, b3;
      int          bad;
      stream.delete();
      stream.push_back(8'h00);
      ck = 8'h00;
      for (int i = 0; i < 256; i++) begin
         iv = 8'(i);
         b0 = {4'h0, iv[3:0]};
         b1 = iv;
         b2 = ~iv;
         b3 = 8'h5A;
         stream.push_back(b0); stream.push_back(b1);
         stream.push_back(b2); stream.push_back(b3);
         ck = ck ^ b0 ^ b1 ^ b2 ^ b3;
         expData[i] = {b0[3:0], b1, b2, b3};
      end
      stream.push_back(ck);
      clearWrites();
      sendAll(0);
      nCompared++;
      if (wrAddr.size() !== 256) begin
         nMismatched++;
         $display("FAIL full_write_count: got %0d required 256", wrAddr.size());
      end
      bad = 0;
      for (int i = 0; i < 256 && i < wrAddr.size(); i++) begin
         nCompared++;
         if (wrAddr[i] !== 8'(i) || wrData[i] !== expData[i]) begin
            nMismatched++;
            bad++;
            if (bad <= 4)
               $display("FAIL full_write_%0d: got %07h@%0d required %07h@%0d",
                        i, wrData[i], wrAddr[i], expData[i], i);
         end
      end
      nCompared++;
      if (oDone !== 1'b1 || oError !== 1'b0 || oCpuReset !== 1'b0 || oWriteAddress !== 8'd0) begin
         nMismatched++;
         $display("FAIL full_status: got done=%b err=%b cpuRst=%b addr=%0d required 1 0 0 0",
                  oDone, oError, oCpuReset, oWriteAddress);
      end
      $display("test_full_256 done: %0d writes", wrAddr.size());
      test_restart();
   endtask

   task automatic test_mid_reset();
      buildGood(8'h9A);
      for (int i = 0; i < 7; i++) sendByte(stream[i], 0);
      Reset = 1'b0;
      #1;
      nCompared++;
      if (oByteReady !== 1'b0 || oCpuReset !== 1'b1 || oWriteEnable !== 1'b0) begin
         nMismatched++;
         $display("FAIL midrst_comb: got rdy=%b cpuRst=%b we=%b required 0 1 0",
                  oByteReady, oCpuReset, oWriteEnable);
      end
      @(negedge Clock);
      nCompared++;
      if (oWriteAddress !== 8'd0 || oInstruction !== 28'd0 || oDone !== 1'b0 || oError !== 1'b0) begin
         nMismatched++;
         $display("FAIL midrst_values: got addr=%0d instr=%07h done=%b err=%b required 0 0000000 0 0",
                  oWriteAddress, oInstruction, oDone, oError);
      end
      Reset = 1'b1;
      #1;
      nCompared++;
      if (oByteReady !== 1'b1) begin
         nMismatched++;
         $display("FAIL midrst_ready: got %b required 1", oByteReady);
      end
      @(negedge Clock);
      clearWrites();
      sendAll(0);
      checkTwoWords("reload", 1'b1);
      $display("test_mid_reset done: %0d writes", wrAddr.size());
   endtask

   // Reset arriving in the WRITE cycle must suppress that strobe.
   task automatic test_reset_in_write();
      test_restart();
      buildGood(8'h9A);
      for (int i = 0; i < 5; i++) sendByte(stream[i], 0);
      Reset = 1'b0;
      #1;
      nCompared++;
      if (oWriteEnable !== 1'b0) begin
         nMismatched++;
         $display("FAIL rst_in_write_we: got %b required 0", oWriteEnable);
      end
      @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      nCompared++;
      if (oByteReady !== 1'b1 || oWriteAddress !== 8'd0) begin
         nMismatched++;
         $display("FAIL rst_in_write_after: got rdy=%b addr=%0d required 1 0", oByteReady, oWriteAddress);
      end
      $display("test_reset_in_write done");
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      test_reset();
      test_good_load();
      test_restart();
      test_bad_checksum();
      test_restart();
      test_bad_opcode();
      test_restart();
      test_gaps();
      test_restart();
      test_full_256();
      test_mid_reset();
      test_reset_in_write();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, the width of the instruction-memory write address.
REQ-002 SHALL have port Clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit; reset is synchronous and active-low (0 = reset, sampled on rising Clock).
REQ-004 SHALL have port iByteValid, input, 1 bit: the source offers iByte this cycle.
REQ-005 SHALL have port iByte, input, 8 bits: serial stream byte.
REQ-006 SHALL have port oByteReady, output, 1 bit: the loader accepts iByte this cycle.
REQ-007 SHALL have port oWriteEnable, output, 1 bit: one-cycle write strobe to the instruction memory.
REQ-008 SHALL have port oWriteAddress, output, ADDR_W bits: write address.
REQ-009 SHALL have port oInstruction, output, 28 bits: instruction word to write.
REQ-010 SHALL have port oCpuReset, output, 1 bit, active-high: holds the processor in reset while loading.
REQ-011 SHALL have port iStart, input, 1 bit: request a reload from DONE or ERROR.
REQ-012 SHALL have ports oDone and oError, outputs, 1 bit each: load status.

Function
REQ-013 SHALL transfer a byte only in a cycle where iByteValid=1 and oByteReady=1; no other cycle changes byte-related state.
REQ-014 SHALL use stream format: header byte N (N=0 means 256 words), then N words of 4 bytes each, most significant byte first, then one checksum byte.
REQ-015 SHALL use FSM states HDR, DATA, WRITE, CHECK, DONE, ERROR; oByteReady=1 in HDR, DATA and CHECK only.
REQ-016 HDR: accepting a byte SHALL latch N, clear the running XOR, load it with the byte, clear the word counter, and go to DATA.
REQ-017 DATA: SHALL track byte index 0..3 and XOR each accepted byte into the running checksum.
REQ-018 DATA, byte index 0: upper nibble nonzero SHALL cause transition to ERROR with no write. The lower nibble SHALL form oInstruction[27:24].
REQ-019 After byte index 3 is accepted, the FSM SHALL enter WRITE. oWriteEnable=1 SHALL be asserted for exactly that one cycle (latency 1 cycle after the 4th byte), with the stable assembled word and the current address.
REQ-020 On leaving WRITE, the FSM SHALL increment oWriteAddress modulo 2^ADDR_W and the word counter. It SHALL go to CHECK if the counter equals N (256 when N=0), else to DATA with byte index 0.
REQ-021 CHECK: if the accepted byte equals the running XOR, the FSM SHALL go to DONE; otherwise it SHALL go to ERROR.
REQ-022 oCpuReset SHALL be 1 in every state except DONE. oDone=1 only in DONE. oError=1 only in ERROR.
REQ-023 DONE or ERROR with iStart=1: the FSM SHALL go to HDR next cycle, clear oWriteAddress, oDone and oError, and set oCpuReset=1.
REQ-024 iStart SHALL be ignored in HDR, DATA, WRITE and CHECK.
REQ-025 oWriteEnable SHALL never be 1 outside WRITE. Words already written before an ERROR SHALL remain; they are not rolled back.
REQ-026 oInstruction and oWriteAddress SHALL be registered and hold their last value outside WRITE.

Reset
REQ-027 While Reset=0: state SHALL be HDR, oByteReady=0, oWriteEnable=0, oWriteAddress=0, oInstruction=0, oCpuReset=1, oDone=0, oError=0, and byte index, word counter and XOR SHALL be 0.
REQ-028 Reset=0 mid-load SHALL abort the load with no write strobe in that cycle. The first cycle after Reset returns to 1 SHALL have oByteReady=1 in HDR.

Verification
REQ-029 Stream 02, 01 23 45 67, 0A BC DE F0, then checksum 0x02^0x01^0x23^0x45^0x67^0x0A^0xBC^0xDE^0xF0 -> writes 0x1234567 @0 and 0xABCDEF0 @1, then oDone=1 and oCpuReset=0.
REQ-030 Same stream with a wrong checksum byte -> both writes occur, then oError=1, oCpuReset=1, oDone=0.
REQ-031 Stream 01, then 1F as byte 0 -> ERROR immediately, oWriteEnable never asserts.
REQ-032 Random iByteValid gaps and oByteReady low in WRITE -> no byte lost or duplicated; the result is identical to the gap-free run.
REQ-033 Header 00 with 256 words and correct checksum -> 256 strobes at addresses 0..255, no wrap before DONE. Then iStart=1 -> HDR, address 0, oCpuReset=1.
REQ-034 Reset=0 asserted after the 2nd data byte -> all outputs at reset values. A new full stream then loads correctly from address 0.
